// File: rtl/jedro_1_decoder.sv
// jedro_1 decode stage: RV32I OP / OP-IMM / LUI into ALU op-select and operand controls,
// with one registered output stage under a valid/ready handshake.
module jedro_1_decoder #(
  parameter int DATA_WIDTH   = 32,
  parameter int ALU_OP_WIDTH = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [DATA_WIDTH-1:0]   instr_i,
  input  logic                    instr_valid_i,
  output logic                    instr_ready_o,
  output logic [ALU_OP_WIDTH-1:0] alu_op_sel_o,
  output logic [4:0]              rs1_addr_o,
  output logic [4:0]              rs2_addr_o,
  output logic [4:0]              rd_addr_o,
  output logic                    rd_we_o,
  output logic [DATA_WIDTH-1:0]   imm_o,
  output logic                    opb_imm_o,
  output logic                    opa_zero_o,
  output logic                    illegal_o,
  output logic                    dec_valid_o,
  input  logic                    dec_ready_i
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] F7_ZERO    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;
  localparam logic [2:0] F3_ADD     = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SR      = 3'b101;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD = '0;

  function automatic logic signed [DATA_WIDTH-1:0] sext_i_imm(input logic [11:0] field);
    return {{(DATA_WIDTH-12){field[11]}}, field};
  endfunction

  function automatic logic signed [DATA_WIDTH-1:0] upper_imm(input logic [19:0] field);
    return {field, {(DATA_WIDTH-20){1'b0}}};
  endfunction

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd_field;

  assign opcode   = instr_i[6:0];
  assign funct3   = instr_i[14:12];
  assign funct7   = instr_i[31:25];
  assign rd_field = instr_i[11:7];

  // Stage p0: combinational decode of the presented instruction
  logic                           legal_p0;
  logic                           bit3_p0;
  logic                           opb_imm_p0;
  logic                           opa_zero_p0;
  logic signed [DATA_WIDTH-1:0]   imm_p0;
  logic [4:0]                     rs1_p0;
  logic [4:0]                     rs2_p0;
  logic [ALU_OP_WIDTH-1:0]        op_sel_p0;
  logic                           rd_we_p0;

  always_comb begin
    legal_p0    = 1'b0;
    bit3_p0     = 1'b0;
    opb_imm_p0  = 1'b0;
    opa_zero_p0 = 1'b0;
    imm_p0      = '0;
    rs1_p0      = instr_i[19:15];
    rs2_p0      = instr_i[24:20];
    // opcode includes instr[1:0], so compressed encodings fall to default
    case (opcode)
      OPC_OP: begin
        if (funct7 == F7_ZERO) begin
          legal_p0 = 1'b1;
        end else if (funct7 == F7_ALT && (funct3 == F3_ADD || funct3 == F3_SR)) begin
          legal_p0 = 1'b1;
          bit3_p0  = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        opb_imm_p0 = 1'b1;
        imm_p0     = sext_i_imm(instr_i[31:20]);
        // instr[30] is immediate data here except for shift-right
        case (funct3)
          F3_SLL: legal_p0 = (funct7 == F7_ZERO);
          F3_SR: begin
            if (funct7 == F7_ZERO) begin
              legal_p0 = 1'b1;
            end else if (funct7 == F7_ALT) begin
              legal_p0 = 1'b1;
              bit3_p0  = 1'b1;
            end
          end
          default: legal_p0 = 1'b1;
        endcase
      end
      OPC_LUI: begin
        legal_p0    = 1'b1;
        opb_imm_p0  = 1'b1;
        opa_zero_p0 = 1'b1;
        imm_p0      = upper_imm(instr_i[31:12]);
        rs1_p0      = '0;
        rs2_p0      = '0;
      end
      default: legal_p0 = 1'b0;
    endcase
  end

  assign op_sel_p0 = (legal_p0 && opcode != OPC_LUI)
                   ? ALU_OP_WIDTH'({bit3_p0, funct3}) : ALU_ADD;
  assign rd_we_p0  = legal_p0 && (rd_field != 5'd0);

  // Stage p1: registered decode output, held while downstream stalls
  logic                           vld_p1;
  logic [ALU_OP_WIDTH-1:0]        op_sel_p1;
  logic [4:0]                     rs1_p1;
  logic [4:0]                     rs2_p1;
  logic [4:0]                     rd_p1;
  logic                           rd_we_p1;
  logic signed [DATA_WIDTH-1:0]   imm_p1;
  logic                           opb_imm_p1;
  logic                           opa_zero_p1;
  logic                           illegal_p1;
  logic                           accept;

  assign instr_ready_o = !vld_p1 || dec_ready_i;
  assign accept        = instr_valid_i && instr_ready_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_p1      <= 1'b0;
      op_sel_p1   <= ALU_ADD;
      rs1_p1      <= '0;
      rs2_p1      <= '0;
      rd_p1       <= '0;
      rd_we_p1    <= 1'b0;
      imm_p1      <= '0;
      opb_imm_p1  <= 1'b0;
      opa_zero_p1 <= 1'b0;
      illegal_p1  <= 1'b0;
    end else if (accept) begin
      vld_p1      <= 1'b1;
      op_sel_p1   <= op_sel_p0;
      rs1_p1      <= rs1_p0;
      rs2_p1      <= rs2_p0;
      rd_p1       <= rd_field;
      rd_we_p1    <= rd_we_p0;
      imm_p1      <= imm_p0;
      opb_imm_p1  <= opb_imm_p0;
      opa_zero_p1 <= opa_zero_p0;
      illegal_p1  <= !legal_p0;
    end else if (dec_ready_i) begin
      vld_p1 <= 1'b0;
    end
  end

  assign dec_valid_o  = vld_p1;
  assign alu_op_sel_o = op_sel_p1;
  assign rs1_addr_o   = rs1_p1;
  assign rs2_addr_o   = rs2_p1;
  assign rd_addr_o    = rd_p1;
  assign rd_we_o      = rd_we_p1;
  assign imm_o        = imm_p1;
  assign opb_imm_o    = opb_imm_p1;
  assign opa_zero_o   = opa_zero_p1;
  assign illegal_o    = illegal_p1;

endmodule

// File: doc/jedro_1_decoder.md
Name: jedro_1_decoder

Overview:
- Decode stage of the jedro_1 core; produces the operation select and operand controls consumed by the jedro_1_alu, i.e. it is the source end of the ALU op-select and operand interface.
- Accepts 32-bit RV32I instructions over a valid/ready handshake and decodes OP, OP-IMM and LUI.
- Presents the decoded fields in a single registered output stage with its own valid/ready handshake, so the stage can stall.

Parameters:
- DATA_WIDTH, 32, width of the instruction and immediate words.
- ALU_OP_WIDTH, 4, width of the ALU op select.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- instr_i  in  32  instruction word.
- instr_valid_i  in  1  instr_i is valid.
- instr_ready_o  out  1  the decoder accepts instr_i this cycle.
- alu_op_sel_o  out  4  ALU op select (encoding below).
- rs1_addr_o  out  5  register-file read address A.
- rs2_addr_o  out  5  register-file read address B.
- rd_addr_o  out  5  destination register.
- rd_we_o  out  1  destination write enable.
- imm_o  out  32  sign-extended immediate.
- opb_imm_o  out  1  1: ALU opb is imm_o; 0: ALU opb is rs2 data.
- opa_zero_o  out  1  1: ALU opa is forced to 0 (LUI).
- illegal_o  out  1  instruction is not supported.
- dec_valid_o  out  1  decoded outputs are valid.
- dec_ready_i  in  1  the downstream stage accepts the decoded outputs.

Behaviour:
- ALU op encoding is {bit3, funct3}, with bit3 = 1 selecting subtract (opb inverted) or arithmetic shift:
  - ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111.
- Handshake:
  - instr_ready_o = !dec_valid_o || dec_ready_i (combinational).
  - An instruction is accepted when instr_valid_i && instr_ready_o.
  - On accept, all decoded outputs are registered and dec_valid_o = 1 on the next cycle. Latency is 1 cycle.
  - If dec_valid_o && !dec_ready_i, every output holds stable and no instruction is accepted.
  - If dec_ready_i is high with no new accept, dec_valid_o clears next cycle.
  - A simultaneous accept and dec_ready_i gives back-to-back throughput of 1 instruction per cycle.
- Reset (asynchronous, active-high, takes effect mid-operation):
  - Every output register is cleared to 0, including dec_valid_o and illegal_o. alu_op_sel_o = ADD (0000).
  - Any pending decoded instruction is discarded.
  - instr_ready_o = 1 while rst_i is low after reset.
- Decoding is by opcode instr[6:0].
- OP (0110011):
  - funct7 = 0000000: any funct3 is legal.
  - funct7 = 0100000: legal only with funct3 000 (SUB) or 101 (SRA).
  - Settings: bit3 = instr[30], opb_imm_o = 0, imm_o = 0.
- OP-IMM (0010011):
  - imm_o = sign-extended instr[31:20]; opb_imm_o = 1.
  - bit3 is 0 for all funct3 except 101. ADDI with instr[30] = 1 (negative immediate) must decode as ADD, never SUB.
  - funct3 001 (SLLI) requires instr[31:25] = 0000000.
  - funct3 101 requires instr[31:25] = 0000000 (SRLI) or 0100000 (SRAI, bit3 = 1).
  - imm_o carries the raw sign-extended field; the ALU uses only the low 5 bits for shifts.
- LUI (0110111):
  - alu_op_sel_o = ADD, opa_zero_o = 1, opb_imm_o = 1.
  - imm_o = {instr[31:12], 12'b0}.
  - rs1_addr_o = 0 and rs2_addr_o = 0.
- rs1_addr_o = instr[19:15], rs2_addr_o = instr[24:20] and rd_addr_o = instr[11:7], except as overridden for LUI.
- rd_we_o = legal && rd != 0. Writes to x0 are suppressed at decode.
- Any other opcode, or a funct7 violation:
  - illegal_o = 1, rd_we_o = 0, alu_op_sel_o = ADD.
  - dec_valid_o still asserts, and the illegal instruction is handshaked like any other.
- instr[1:0] != 11 is illegal.

Test Plan:
- Reset with dec_valid_o = 1 and dec_ready_i = 0 -> all outputs 0 and instr_ready_o = 1.
- add x3,x1,x2 (0x002081B3) accepted -> next cycle dec_valid_o = 1, op = 0000, rs1 = 1, rs2 = 2, rd = 3, rd_we = 1, opb_imm = 0.
- Stall: after addi x5,x0,-1 (0xFFF00293), hold dec_ready_i = 0 for 3 cycles -> outputs stable, instr_ready_o = 0, op = 0000 (not SUB), imm = 0xFFFFFFFF.
- srai x1,x1,3 (0x4030D093) -> op = 1101, imm[4:0] = 3, legal.
- Illegal cases -> illegal_o = 1, rd_we_o = 0, dec_valid_o = 1:
  - slli with funct7 = 0100000 (0x40309093).
  - OP with funct7 = 0000001 (0x022081B3).
- Back-to-back stream of 4 instructions with dec_ready_i = 1 -> 4 decodes in 4 consecutive cycles; lui x0,0x12345 -> rd_we = 0, imm = 0x12345000, opa_zero = 1.
